// File: rtl/axi_rd_slave_pkg.sv
// Shared AXI read-responder constants: response codes, burst encodings,
// field widths and the responder FSM state encoding.
package axi_rd_slave_pkg;

    localparam int SIZE_WIDTH  = 3;
    localparam int BURST_WIDTH = 2;
    localparam int RESP_WIDTH  = 2;

    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_WIDTH-1:0] RESP_DECERR = 2'b11;

    localparam logic [BURST_WIDTH-1:0] BURST_FIXED = 2'b00;
    localparam logic [BURST_WIDTH-1:0] BURST_INCR  = 2'b01;
    localparam logic [BURST_WIDTH-1:0] BURST_WRAP  = 2'b10;
    localparam logic [BURST_WIDTH-1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_SEND = 2'b10
    } state_t;

endpackage

// File: rtl/axi_rd_slave_if.sv
// AXI4 read address / read data channel bundle. The slave modport is the
// memory-side responder view, the master modport is the requester view.
interface axi_rd_slave_if
    import axi_rd_slave_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 64
);

    logic                   ar_valid_i;
    logic                   ar_ready_o;
    logic [ID_WIDTH-1:0]    ar_id_i;
    logic [ADDR_WIDTH-1:0]  ar_addr_i;
    logic [LEN_WIDTH-1:0]   ar_len_i;
    logic [SIZE_WIDTH-1:0]  ar_size_i;
    logic [BURST_WIDTH-1:0] ar_burst_i;

    logic                   r_valid_o;
    logic                   r_ready_i;
    logic [ID_WIDTH-1:0]    r_id_o;
    logic [DATA_WIDTH-1:0]  r_data_o;
    logic [RESP_WIDTH-1:0]  r_resp_o;
    logic                   r_last_o;
    logic                   r_user_o;

    modport slave (
        input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        input  r_ready_i,
        output ar_ready_o,
        output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o
    );

    modport master (
        output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
        output r_ready_i,
        input  ar_ready_o,
        input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, r_user_o
    );

endinterface

// File: rtl/axi_rd_slave_burst_addr_gen.sv
// Combinational AXI burst address step: given the current beat address and
// the burst attributes, produce the next beat address and flag bursts that
// must be answered with SLVERR. Shared between the read and write responders.
module axi_burst_addr_gen
    import axi_rd_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_SIZE   = 3
) (
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [SIZE_WIDTH-1:0]  i_size,
    input  logic [LEN_WIDTH-1:0]   i_len,
    input  logic [BURST_WIDTH-1:0] i_burst,
    output logic [ADDR_WIDTH-1:0]  o_nextAddr,
    output logic                   o_burstErr
);

    localparam logic [SIZE_WIDTH-1:0] MAX_SIZE_L = SIZE_WIDTH'(MAX_SIZE);

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_window;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_sum;
    logic                  w_wrapLenOk;

    // Next address: FIXED holds, INCR steps by the beat size, WRAP steps
    // inside an aligned window of (len+1) beats and folds back to its base.
    always_comb begin
        w_step     = ADDR_WIDTH'(1) << i_size;
        w_window   = (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size;
        w_mask     = w_window - ADDR_WIDTH'(1);
        w_sum      = i_addr + w_step;
        o_nextAddr = i_addr;
        case (i_burst)
            BURST_FIXED: o_nextAddr = i_addr;
            BURST_INCR:  o_nextAddr = w_sum;
            BURST_WRAP:  o_nextAddr = (i_addr & ~w_mask) | (w_sum & w_mask);
            default:     o_nextAddr = i_addr;
        endcase
    end

    // Reserved cases: the 2'b11 burst code, a beat wider than the data bus,
    // and WRAP bursts whose length is not 2, 4, 8 or 16 beats.
    always_comb begin
        w_wrapLenOk = (i_len == LEN_WIDTH'(1))  || (i_len == LEN_WIDTH'(3)) ||
                      (i_len == LEN_WIDTH'(7))  || (i_len == LEN_WIDTH'(15));
        o_burstErr  = (i_size > MAX_SIZE_L) ||
                      (i_burst == BURST_RSVD) ||
                      ((i_burst == BURST_WRAP) && !w_wrapLenOk);
    end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI4 read responder in front of a single-port synchronous SRAM. Serves
// one AR request at a time and returns len+1 beats, one every two cycles
// at best: a read cycle to the SRAM, then a cycle presenting the beat.
// Optional feature macro: AXI_RD_SLAVE_RANGE_CHECK_EN -- beats whose
// address falls outside the memory window answer DECERR without reading.
module axi_rd_slave
    import axi_rd_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int MEM_AW     = 16
`ifdef AXI_RD_SLAVE_RANGE_CHECK_EN
    ,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(64'h8000_0000)
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axi_rd_slave_if.slave         axi,
    output logic                  mem_ren_o,
    output logic [MEM_AW-1:0]     mem_raddr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int OFF = $clog2(DATA_WIDTH/8);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [ID_WIDTH-1:0]    r_id;
    logic [ADDR_WIDTH-1:0]  r_beatAddr;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [SIZE_WIDTH-1:0]  r_size;
    logic [BURST_WIDTH-1:0] r_burst;
    logic                   r_burstErr;
    logic                   r_beatRd;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [RESP_WIDTH-1:0]  r_resp;

    logic [ADDR_WIDTH-1:0]  w_firstAddr;
    logic [ADDR_WIDTH-1:0]  w_genAddr;
    logic [SIZE_WIDTH-1:0]  w_genSize;
    logic [LEN_WIDTH-1:0]   w_genLen;
    logic [BURST_WIDTH-1:0] w_genBurst;
    logic [ADDR_WIDTH-1:0]  w_nextAddr;
    logic                   w_genErr;
    logic                   w_firstOk;
    logic                   w_nextOk;
    logic                   w_firstRd;
    logic                   w_nextRd;
    logic                   w_arFire;
    logic                   w_rFire;
    logic                   w_last;

    // The first beat address is the request address aligned down to the beat size.
    assign w_firstAddr = axi.ar_addr_i &
                         ~((ADDR_WIDTH'(1) << axi.ar_size_i) - ADDR_WIDTH'(1));

    // While idle the generator judges the incoming request; afterwards it
    // steps the latched burst.
    assign w_genAddr  = (r_state == ST_IDLE) ? axi.ar_addr_i  : r_beatAddr;
    assign w_genSize  = (r_state == ST_IDLE) ? axi.ar_size_i  : r_size;
    assign w_genLen   = (r_state == ST_IDLE) ? axi.ar_len_i   : r_len;
    assign w_genBurst = (r_state == ST_IDLE) ? axi.ar_burst_i : r_burst;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .MAX_SIZE   (OFF)
    ) u_addrGen (
        .i_addr     (w_genAddr),
        .i_size     (w_genSize),
        .i_len      (w_genLen),
        .i_burst    (w_genBurst),
        .o_nextAddr (w_nextAddr),
        .o_burstErr (w_genErr)
    );

`ifdef AXI_RD_SLAVE_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] WINDOW_BYTES = ADDR_WIDTH'(1) << (MEM_AW + OFF);

    function automatic logic inWindow(input logic [ADDR_WIDTH-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < WINDOW_BYTES);
    endfunction

    assign w_firstOk = inWindow(w_firstAddr);
    assign w_nextOk  = inWindow(w_nextAddr);
`else
    assign w_firstOk = 1'b1;
    assign w_nextOk  = 1'b1;
`endif

    // A beat touches the SRAM only when the burst is legal and its address is mapped.
    assign w_firstRd = !w_genErr && w_firstOk;
    assign w_nextRd  = !r_burstErr && w_nextOk;
    assign w_last    = (r_cnt == '0);

    // State register for the IDLE -> WAIT -> SEND responder loop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state, handshakes and the SRAM read strobe; the strobe fires only
    // on the AR handshake or on a non-final R handshake, never during a stall.
    always_comb begin
        w_nextState    = r_state;
        w_arFire       = 1'b0;
        w_rFire        = 1'b0;
        axi.ar_ready_o = 1'b0;
        axi.r_valid_o  = 1'b0;
        axi.r_last_o   = 1'b0;
        mem_ren_o      = 1'b0;
        mem_raddr_o    = w_firstAddr[MEM_AW+OFF-1:OFF];
        case (r_state)
            ST_IDLE: begin
                axi.ar_ready_o = reset_n;
                if (axi.ar_valid_i && reset_n) begin
                    w_arFire    = 1'b1;
                    mem_ren_o   = w_firstRd;
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_nextState = ST_SEND;
            end
            ST_SEND: begin
                axi.r_valid_o = 1'b1;
                axi.r_last_o  = w_last;
                mem_raddr_o   = w_nextAddr[MEM_AW+OFF-1:OFF];
                if (axi.r_ready_i && reset_n) begin
                    w_rFire = 1'b1;
                    if (w_last) begin
                        w_nextState = ST_IDLE;
                    end else begin
                        mem_ren_o   = w_nextRd;
                        w_nextState = ST_WAIT;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: latch the request, step the beat address on each
    // accepted beat, and capture the SRAM word (or an error) in WAIT so the
    // presented beat stays frozen however long the master stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_id       <= '0;
            r_beatAddr <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_burstErr <= 1'b0;
            r_beatRd   <= 1'b0;
            r_data     <= '0;
            r_resp     <= RESP_OKAY;
        end else begin
            if (w_arFire) begin
                r_id       <= axi.ar_id_i;
                r_beatAddr <= w_firstAddr;
                r_len      <= axi.ar_len_i;
                r_cnt      <= axi.ar_len_i;
                r_size     <= axi.ar_size_i;
                r_burst    <= axi.ar_burst_i;
                r_burstErr <= w_genErr;
                r_beatRd   <= w_firstRd;
            end else if (w_rFire && !w_last) begin
                r_cnt      <= r_cnt - LEN_WIDTH'(1);
                r_beatAddr <= w_nextAddr;
                r_beatRd   <= w_nextRd;
            end
            if (r_state == ST_WAIT) begin
                if (r_beatRd) begin
                    r_data <= mem_rdata_i;
                    r_resp <= RESP_OKAY;
                end else begin
                    r_data <= '0;
                    r_resp <= r_burstErr ? RESP_SLVERR : RESP_DECERR;
                end
            end
        end
    end

    assign axi.r_id_o   = r_id;
    assign axi.r_data_o = r_data;
    assign axi.r_resp_o = r_resp;
    assign axi.r_user_o = 1'b0;

endmodule
